// File: rtl/flash_seq_ctrl_if.sv
// Command/response handshake between the register block and flash_seq_ctrl.
//   cmd_valid/cmd_ready : command handshake (accept when both high)
//   cmd_op/row/wdata    : command payload, latched on accept
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata/rsp_err   : response payload, valid with rsp_valid
//   busy                : sequencer is not idle
interface flash_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/flash_seq_ctrl.sv
// Sequencer for the 8x8 NAND-style flash array macro: runs timed read,
// program and erase sequences and captures sense-amp data.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus                : command/response handshake (slave side)
//   ssl/gsl            : string/ground select, one bit per block
//   wl0/wl1            : wordlines of block 0 / block 1
//   sl/vbpw            : erase source line / p-well bias enables
//   sen1/sen2/out_en   : sense-amp precharge / evaluate / output enables
//   sa_out             : sense-amp data from the macro
//   bl_oe/bl_do        : bitline drive enable and program data
// All outputs are registered: the decode below works on next-state values.
module flash_seq_ctrl #(
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_PRE   = 8,
    parameter int unsigned T_SENSE = 8,
    parameter int unsigned T_PGM   = 64,
    parameter int unsigned T_ERS   = 256,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    flash_seq_ctrl_if.slave       bus,
    output logic [1:0]            ssl,
    output logic [1:0]            gsl,
    output logic [3:0]            wl0,
    output logic [3:0]            wl1,
    output logic                  sl,
    output logic                  vbpw,
    output logic                  sen1,
    output logic                  sen2,
    output logic [3:0]            out_en,
    input  logic [7:0]            sa_out,
    output logic                  bl_oe,
    output logic [7:0]            bl_do
);

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_PGM  = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_PRE, S_SENSE, S_LATCH, S_PGM, S_ERS, S_RECOV, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic [2:0]       r_row, w_row_nxt;
    logic [7:0]       r_wdata, w_wdata_nxt;
    logic             w_accept, w_cnt_zero;

    // next-cycle output values
    logic             w_sel, w_ssl_on;
    logic [3:0]       w_wl_oh, w_wl_pat;
    logic [1:0]       w_ssl, w_gsl;
    logic [3:0]       w_wl0, w_wl1, w_out_en;
    logic             w_sl, w_vbpw, w_sen1, w_sen2, w_bl_oe;
    logic [7:0]       w_bl_do;
    logic             w_rsp_valid, w_rsp_err;

    // output registers
    logic [1:0]       r_ssl, r_gsl;
    logic [3:0]       r_wl0, r_wl1, r_out_en;
    logic             r_sl, r_vbpw, r_sen1, r_sen2, r_bl_oe;
    logic [7:0]       r_bl_do, r_rdata;
    logic             r_rsp_valid, r_rsp_err, r_cmd_ready, r_busy;

    // next state, counter and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_zero  = (r_cnt == '0);
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        w_accept    = bus.cmd_valid && (r_state == S_IDLE);
        w_op_nxt    = w_accept ? bus.cmd_op    : r_op;
        w_row_nxt   = w_accept ? bus.cmd_row   : r_row;
        w_wdata_nxt = w_accept ? bus.cmd_wdata : r_wdata;
        w_sel       = 1'b0;
        w_ssl_on    = 1'b0;
        w_wl_pat    = 4'h0;
        w_wl_oh     = 4'(4'b0001 << w_row_nxt[1:0]);
        w_sl        = 1'b0;
        w_vbpw      = 1'b0;
        w_sen1      = 1'b0;
        w_sen2      = 1'b0;
        w_out_en    = 4'h0;
        w_bl_oe     = 1'b0;
        w_bl_do     = 8'h00;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.cmd_op == OP_ILL) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = CNT_W'(T_SETUP - 1);
                    end
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    if (r_op == OP_READ) begin
                        w_state_nxt = S_PRE;
                        w_cnt_nxt   = CNT_W'(T_PRE - 1);
                    end else if (r_op == OP_PGM) begin
                        w_state_nxt = S_PGM;
                        w_cnt_nxt   = CNT_W'(T_PGM - 1);
                    end else begin
                        w_state_nxt = S_ERS;
                        w_cnt_nxt   = CNT_W'(T_ERS - 1);
                    end
                end
            end
            S_PRE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_SENSE;
                    w_cnt_nxt   = CNT_W'(T_SENSE - 1);
                end
            end
            S_SENSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_LATCH;
                    w_cnt_nxt   = '0;
                end
            end
            S_LATCH: w_state_nxt = S_DONE;
            S_PGM, S_ERS: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_RECOV;
                    w_cnt_nxt   = CNT_W'(T_SETUP - 1);
                end
            end
            S_RECOV: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // array pattern for the state being entered
        case (w_state_nxt)
            S_SETUP: begin
                if (w_op_nxt == OP_READ) begin
                    w_sel    = 1'b1;
                    w_wl_pat = ~w_wl_oh;
                end else if (w_op_nxt == OP_PGM) begin
                    w_ssl_on = 1'b1;
                    w_bl_oe  = 1'b1;
                    w_bl_do  = w_wdata_nxt;
                end
            end
            S_PRE: begin
                w_sel    = 1'b1;
                w_wl_pat = ~w_wl_oh;
                w_sen1   = 1'b1;
            end
            S_SENSE: begin
                w_sel    = 1'b1;
                w_wl_pat = ~w_wl_oh;
                w_sen2   = 1'b1;
            end
            S_LATCH: begin
                w_sel    = 1'b1;
                w_wl_pat = ~w_wl_oh;
                w_out_en = 4'hF;
            end
            S_PGM: begin
                w_ssl_on = 1'b1;
                w_bl_oe  = 1'b1;
                w_bl_do  = w_wdata_nxt;
                w_wl_pat = w_wl_oh;
            end
            S_ERS: begin
                w_sl   = 1'b1;
                w_vbpw = 1'b1;
            end
            S_DONE: begin
                w_rsp_valid = 1'b1;
                w_rsp_err   = (w_op_nxt == OP_ILL);
            end
            default: ;
        endcase

        // read drives both selects; program drives string select only
        w_ssl = (w_sel || w_ssl_on) ? (w_row_nxt[2] ? 2'b10 : 2'b01) : 2'b00;
        w_gsl = w_sel ? (w_row_nxt[2] ? 2'b10 : 2'b01) : 2'b00;
        w_wl0 = w_row_nxt[2] ? 4'h0 : w_wl_pat;
        w_wl1 = w_row_nxt[2] ? w_wl_pat : 4'h0;
    end

    // state, command and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 2'b00;
            r_row       <= 3'b000;
            r_wdata     <= 8'h00;
            r_ssl       <= 2'b00;
            r_gsl       <= 2'b00;
            r_wl0       <= 4'h0;
            r_wl1       <= 4'h0;
            r_sl        <= 1'b0;
            r_vbpw      <= 1'b0;
            r_sen1      <= 1'b0;
            r_sen2      <= 1'b0;
            r_out_en    <= 4'h0;
            r_bl_oe     <= 1'b0;
            r_bl_do     <= 8'h00;
            r_rdata     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_row       <= w_row_nxt;
            r_wdata     <= w_wdata_nxt;
            r_ssl       <= w_ssl;
            r_gsl       <= w_gsl;
            r_wl0       <= w_wl0;
            r_wl1       <= w_wl1;
            r_sl        <= w_sl;
            r_vbpw      <= w_vbpw;
            r_sen1      <= w_sen1;
            r_sen2      <= w_sen2;
            r_out_en    <= w_out_en;
            r_bl_oe     <= w_bl_oe;
            r_bl_do     <= w_bl_do;
            // sense data is captured at the end of the LATCH cycle
            if (r_state == S_LATCH) begin
                r_rdata <= sa_out;
            end
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign ssl           = r_ssl;
    assign gsl           = r_gsl;
    assign wl0           = r_wl0;
    assign wl1           = r_wl1;
    assign sl            = r_sl;
    assign vbpw          = r_vbpw;
    assign sen1          = r_sen1;
    assign sen2          = r_sen2;
    assign out_en        = r_out_en;
    assign bl_oe         = r_bl_oe;
    assign bl_do         = r_bl_do;

endmodule
